pipe_ctrl_unit: RTL
===================

Name: pipe_ctrl_unit

Overview:
- Registered ID-stage control unit for the five-stage MIPS pipeline. Decodes the IF/ID instruction and drives the ID/EX control register.
- Adds three capabilities: load-use hazard stall, branch flush, and a halt drain state machine.
- Parametrised for register-address and ALU-control width, with an optional extended ISA.
- Outputs update on the rising edge of Clk; there is no negedge decode.

Parameters:
RA_W, 5, register address width
ALUOP_W, 4, AluCtrl width (≥4; codes zero-extended)
EXT_ISA, 1, 1 enables xor/nor/srl/lui; 0 decodes them as illegal
DRAIN_CYCLES, 3, bubble cycles after halt before Halt asserts (1..15)

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  IF/ID slot holds a real instruction
inst  in  32  IF/ID instruction
branch_taken  in  1  EX resolved taken branch/jump; flush ID
stall  out  1  combinational; freeze PC and IF/ID
ctrl_valid  out  1  ID/EX slot holds a real instruction
AluCtrl  out  ALUOP_W  ALU operation
Reg_Dst, ALU_Src1, ALU_Src2, Mem_Write, Mem_Read, MemtoReg, Reg_Write  out  1 each  datapath controls
Branch_Eq, Branch_Ne, Jump  out  1 each  branch/jump type
ex_wreg  out  RA_W  destination register of the ID/EX instruction (rd if Reg_Dst, else rt)
illegal  out  1  one-cycle pulse: unknown opcode/funct decoded
Halt  out  1  sticky; pipeline halted

Behaviour:
- Reset (async, Rst_n=0): all registered outputs 0, state=RUN, drain counter 0. stall is 0 during reset.
- Latency: one cycle. inst at edge N appears as controls after edge N.
- Decode encodings (AluCtrl):
  - R-type (op 000000): add 100000→0010, sub 100010→0110, and 100100→0000, or 100101→0001, slt 101010→0111, sll 000000→1100 with ALU_Src1=1.
  - EXT_ISA=1 only: xor 100110→0011, nor 100111→1101, srl 000010→1000 with ALU_Src1=1.
  - R-type: Reg_Dst=1, Reg_Write=1.
  - addi 001000→0010, andi 001100→0000, ori 001101→0001, EXT_ISA lui 001111→1001: ALU_Src2=1, Reg_Write=1.
  - lw 100011: 0010, ALU_Src2, Mem_Read, MemtoReg, Reg_Write.
  - sw 101011: 0010, ALU_Src2, Mem_Write.
  - beq 000100: 0110, Branch_Eq. bne 000101: 0110, Branch_Ne. j 000010: Jump.
  - halt 111111: no controls; triggers the halt sequence.
- Bubble: all controls 0, ctrl_valid=0, ex_wreg=0.
- Source usage:
  - rs is read by everything except sll/srl/lui/j/halt.
  - rt is read by R-type, sw, beq, bne.
- Load-use stall: stall=1 when all of the following hold:
  - state=RUN and inst_valid and !branch_taken;
  - registered Mem_Read=1 and ex_wreg≠0;
  - ex_wreg matches a source register that inst actually reads.
  - Then load a bubble into ID/EX. stall falls the next cycle because the ID/EX now holds a bubble.
- Flush: branch_taken=1 loads a bubble regardless of inst and forces stall=0. A halt or illegal instruction in the flushed slot is ignored.
- Illegal: unknown opcode/funct with inst_valid, not stalled or flushed → bubble, illegal=1 for one cycle.
- State machine:
  - RUN: a valid halt decoded, not stalled or flushed → bubble, counter=DRAIN_CYCLES, go to DRAIN.
  - DRAIN: bubbles only, inst ignored, stall=1 (holds IF). Counter decrements each cycle; at 1 → HALTED.
  - HALTED: bubbles only, Halt=1, stall=1. Only reset exits.
  - branch_taken during DRAIN/HALTED is ignored.
- Reset mid-stall or mid-drain returns to RUN immediately with all outputs 0.

Test Plan:
- Reset, then inst=0x01095020 (add $10,$8,$9) valid → next edge: AluCtrl=0010, Reg_Dst=1, Reg_Write=1, ex_wreg=10, ctrl_valid=1.
- lw $8,0($9) (0x8D280000) followed by add $10,$8,$9 held → stall=1 for exactly one cycle; bubble (ctrl_valid=0) in ID/EX; add issues the following cycle. Repeat with the lw targeting $0 → no stall.
- Load-use condition together with branch_taken=1 → stall=0, bubble, no extra stall cycle.
- halt 0xFC000000, DRAIN_CYCLES=3 → 3 bubble cycles with stall=1, then Halt=1 sticky. Rst_n pulse mid-drain → Halt=0, state RUN, AluCtrl=0.
- EXT_ISA=0, xor 0x01095026 → illegal pulses one cycle, bubble. EXT_ISA=1 → AluCtrl=0011, Reg_Write=1.
- lui 0x3C0A1234 → AluCtrl=1001, ALU_Src2=1, ex_wreg=10, no rs dependency stall even if a prior lw wrote $0's slot (rs=0).

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit for a five-stage MIPS pipeline: registered ID/EX controls,
// load-use stall, branch flush and a halt drain sequence.
module pipe_ctrl_unit #(
  parameter int RA_W         = 5,
  parameter int ALUOP_W      = 4,
  parameter int EXT_ISA      = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               inst_valid,
  input  logic [31:0]        inst,
  input  logic               branch_taken,
  output logic               stall,
  output logic               ctrl_valid,
  output logic [ALUOP_W-1:0] AluCtrl,
  output logic               Reg_Dst,
  output logic               ALU_Src1,
  output logic               ALU_Src2,
  output logic               Mem_Write,
  output logic               Mem_Read,
  output logic               MemtoReg,
  output logic               Reg_Write,
  output logic               Branch_Eq,
  output logic               Branch_Ne,
  output logic               Jump,
  output logic [RA_W-1:0]    ex_wreg,
  output logic               illegal,
  output logic               Halt
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0] state;
  logic [3:0] drain_cnt;

  logic [5:0]      op, funct;
  logic [RA_W-1:0] rs, rt, rd;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rs    = RA_W'(inst[25:21]);
  assign rt    = RA_W'(inst[20:16]);
  assign rd    = RA_W'(inst[15:11]);

  // Immediate and shamt bits do not influence control decode.
  logic unused_inst;
  assign unused_inst = ^inst[10:6];

  logic [3:0] d_alu;
  logic       d_reg_dst, d_src1, d_src2, d_mem_write, d_mem_read, d_memtoreg;
  logic       d_reg_write, d_beq, d_bne, d_jump;
  logic       d_legal, d_halt, use_rs, use_rt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    d_alu       = 4'b0000;
    d_reg_dst   = 1'b0;
    d_src1      = 1'b0;
    d_src2      = 1'b0;
    d_mem_write = 1'b0;
    d_mem_read  = 1'b0;
    d_memtoreg  = 1'b0;
    d_reg_write = 1'b0;
    d_beq       = 1'b0;
    d_bne       = 1'b0;
    d_jump      = 1'b0;
    d_legal     = 1'b1;
    d_halt      = 1'b0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    case (op)
      6'b000000: begin
        d_reg_dst   = 1'b1;
        d_reg_write = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
        case (funct)
          6'b100000: d_alu = 4'b0010;
          6'b100010: d_alu = 4'b0110;
          6'b100100: d_alu = 4'b0000;
          6'b100101: d_alu = 4'b0001;
          6'b101010: d_alu = 4'b0111;
          6'b000000: begin d_alu = 4'b1100; d_src1 = 1'b1; use_rs = 1'b0; end
          6'b100110: if (EXT_ISA != 0) d_alu = 4'b0011; else d_legal = 1'b0;
          6'b100111: if (EXT_ISA != 0) d_alu = 4'b1101; else d_legal = 1'b0;
          6'b000010: begin
            if (EXT_ISA != 0) begin
              d_alu  = 4'b1000;
              d_src1 = 1'b1;
              use_rs = 1'b0;
            end else begin
              d_legal = 1'b0;
            end
          end
          default:   d_legal = 1'b0;
        endcase
      end
      6'b001000: begin d_alu = 4'b0010; d_src2 = 1'b1; d_reg_write = 1'b1; use_rs = 1'b1; end
      6'b001100: begin d_alu = 4'b0000; d_src2 = 1'b1; d_reg_write = 1'b1; use_rs = 1'b1; end
      6'b001101: begin d_alu = 4'b0001; d_src2 = 1'b1; d_reg_write = 1'b1; use_rs = 1'b1; end
      6'b001111: begin
        if (EXT_ISA != 0) begin
          d_alu       = 4'b1001;
          d_src2      = 1'b1;
          d_reg_write = 1'b1;
        end else begin
          d_legal = 1'b0;
        end
      end
      6'b100011: begin
        d_alu       = 4'b0010;
        d_src2      = 1'b1;
        d_mem_read  = 1'b1;
        d_memtoreg  = 1'b1;
        d_reg_write = 1'b1;
        use_rs      = 1'b1;
      end
      6'b101011: begin
        d_alu       = 4'b0010;
        d_src2      = 1'b1;
        d_mem_write = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      6'b000100: begin d_alu = 4'b0110; d_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'b000101: begin d_alu = 4'b0110; d_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'b000010: d_jump = 1'b1;
      6'b111111: d_halt = 1'b1;
      default:   d_legal = 1'b0;
    endcase
  end

  // Only a real, unflushed instruction in RUN can depend on the load in ID/EX.
  logic load_use, accept;
  assign load_use = (state == S_RUN) && inst_valid && !branch_taken && d_legal &&
                    Mem_Read && (ex_wreg != '0) &&
                    ((use_rs && (rs == ex_wreg)) || (use_rt && (rt == ex_wreg)));
  assign stall    = (state != S_RUN) || load_use;
  assign accept   = (state == S_RUN) && inst_valid && !branch_taken && !load_use;

  // NOTE: sequential state uses non-blocking assignments only; the bubble
  // defaults below are overridden later in the same block when an instruction issues.
  // NOTE: every register here has a reset value; there is no memory array to exempt.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_RUN;
      drain_cnt  <= 4'd0;
      ctrl_valid <= 1'b0;
      AluCtrl    <= '0;
      Reg_Dst    <= 1'b0;
      ALU_Src1   <= 1'b0;
      ALU_Src2   <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_Read   <= 1'b0;
      MemtoReg   <= 1'b0;
      Reg_Write  <= 1'b0;
      Branch_Eq  <= 1'b0;
      Branch_Ne  <= 1'b0;
      Jump       <= 1'b0;
      ex_wreg    <= '0;
      illegal    <= 1'b0;
      Halt       <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      AluCtrl    <= '0;
      Reg_Dst    <= 1'b0;
      ALU_Src1   <= 1'b0;
      ALU_Src2   <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_Read   <= 1'b0;
      MemtoReg   <= 1'b0;
      Reg_Write  <= 1'b0;
      Branch_Eq  <= 1'b0;
      Branch_Ne  <= 1'b0;
      Jump       <= 1'b0;
      ex_wreg    <= '0;
      illegal    <= 1'b0;
      case (state)
        S_RUN: begin
          if (accept && !d_legal) begin
            illegal <= 1'b1;
          end else if (accept && d_halt) begin
            state     <= S_DRAIN;
            drain_cnt <= 4'(DRAIN_CYCLES);
          end else if (accept) begin
            ctrl_valid <= 1'b1;
            AluCtrl    <= ALUOP_W'(d_alu);
            Reg_Dst    <= d_reg_dst;
            ALU_Src1   <= d_src1;
            ALU_Src2   <= d_src2;
            Mem_Write  <= d_mem_write;
            Mem_Read   <= d_mem_read;
            MemtoReg   <= d_memtoreg;
            Reg_Write  <= d_reg_write;
            Branch_Eq  <= d_beq;
            Branch_Ne  <= d_bne;
            Jump       <= d_jump;
            ex_wreg    <= d_reg_dst ? rd : rt;
          end
        end
        S_DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            state <= S_HALTED;
            Halt  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: Halt <= 1'b1;
      endcase
    end
  end

endmodule
